ollar_bus_arbiter: RTL and testbench
====================================

Name: ollar_bus_arbiter

Overview:
- Parametrised shared memory/peripheral arbiter for the OLLAR multi-core top level.
- Connects NUM_CORES core bus masters to one shared memory/peripheral slave port.
- Replaces fixed per-core Input/Output/Address/Write wiring with a round-robin req/ack handshake, single-outstanding-transaction sequencing, and a slave timeout with error response.

Parameters:
- NUM_CORES, 4, number of core master ports (2..16).
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- TIMEOUT, 16, cycles to wait for mem_ack before error response (>=2).
- ERR_DATA, 32'hDEADBEEF, read data returned on timeout (truncated/zero-extended to DATA_W).

Ports:
- CLOCK_PIN  in  1  system clock, all logic on rising edge
- RESET_PIN  in  1  reset; one clock; reset is asynchronous and active-high
- core_req  in  NUM_CORES  per-core request; held high until that core's core_ack
- core_write  in  NUM_CORES  per-core 1=write, 0=read
- core_addr  in  NUM_CORES*ADDR_W  packed addresses, core i at [i*ADDR_W +: ADDR_W]
- core_wdata  in  NUM_CORES*DATA_W  packed write data, same packing
- core_ack  out  NUM_CORES  one-hot single-cycle completion pulse
- core_err  out  NUM_CORES  one-hot error flag, valid only with core_ack (timeout)
- core_rdata  out  DATA_W  read data broadcast to all cores, valid when any core_ack=1
- mem_req  out  1  slave request, held until mem_ack or timeout
- mem_write  out  1  latched write flag
- mem_addr  out  ADDR_W  latched address
- mem_wdata  out  DATA_W  latched write data
- mem_rdata  in  DATA_W  slave read data, sampled with mem_ack
- mem_ack  in  1  slave completion, single cycle

Behaviour:
- Reset (async, any state): state=IDLE, last_grant=NUM_CORES-1 (core 0 has top priority first), timer=0. All outputs 0: core_ack, core_err, core_rdata, mem_req, mem_write, mem_addr, mem_wdata.
- FSM states: IDLE, BUSY, RESP.
- IDLE: if core_req != 0, choose winner = first set bit scanning (last_grant+1) mod NUM_CORES upward with wrap. Latch winner, its write/addr/wdata into mem_* regs. Set mem_req=1, timer=0, go BUSY. No request: stay IDLE.
- BUSY: mem_req=1, mem_* outputs held stable; timer increments each cycle.
  - mem_ack=1: capture mem_rdata into core_rdata (write: core_rdata=0), mem_req=0, go RESP.
  - Else timer==TIMEOUT-1: core_rdata=ERR_DATA, set err flag, mem_req=0, go RESP.
  - mem_ack on the same cycle as the timeout boundary: ack wins, no error.
- RESP (exactly one cycle): core_ack[winner]=1, core_err[winner]=err flag, last_grant=winner. Next state IDLE, err flag cleared. core_ack/core_err return to 0 the following cycle.
- Latency with an idle arbiter and 0-wait slave: req sampled at edge k -> mem_req high after edge k; mem_ack at edge k+1 -> core_ack high after edge k+2. Minimum 3 cycles per transaction.
- A core must deassert or change its request on the edge where it samples core_ack. RESP->IDLE adds one bubble, so a stale request is never re-granted.
- core_req changes in BUSY/RESP are ignored. The latched winner is not aborted if its req drops.
- mem_ack in IDLE or RESP is ignored. core_rdata holds its last value until overwritten.
- Fairness: a continuously requesting core waits at most NUM_CORES-1 transactions.
- Reset mid-transaction aborts with no ack to any core. The slave sees mem_req drop asynchronously.

Test Plan:
- Single read: core 2 req, addr=0x100, slave acks 1 cycle later with rdata 0xCAFEF00D -> mem_addr=0x100, mem_write=0, core_ack=4'b0100 for one cycle, core_rdata=0xCAFEF00D, core_err=0, 3 cycles req-to-ack.
- Round-robin: all 4 cores request continuously from reset, each dropping after its ack then re-raising -> grant order 0,1,2,3,0,1; no core granted twice before the others.
- Write with 3-wait slave: core 1 write addr=0x20 wdata=0x12345678 -> mem_write=1, mem_wdata stable for 4 BUSY cycles, core_ack=4'b0010, core_rdata=0.
- Timeout: core 0 read, mem_ack never asserted, TIMEOUT=16 -> mem_req drops after 16 cycles, core_ack[0]=core_err[0]=1, core_rdata=0xDEADBEEF. Next request from core 0 proceeds normally.
- Boundary ack: mem_ack arrives exactly on cycle TIMEOUT-1 -> normal response, core_err=0.
- Reset mid-BUSY: assert RESET_PIN between edges during a core 3 transaction -> mem_req and all outputs 0 immediately, no core_ack. After release, core 0 wins over core 3 when both request.

Source files
------------

// File: rtl/ollar_bus_arbiter.sv
// Round-robin arbiter that funnels NUM_CORES bus masters onto one shared slave port,
// one outstanding transaction at a time, with a slave timeout that returns an error.
module ollar_bus_arbiter #(
   parameter int          NUM_CORES = 4,
   parameter int          ADDR_W    = 32,
   parameter int          DATA_W    = 32,
   parameter int          TIMEOUT   = 16,
   parameter logic [31:0] ERR_DATA  = 32'hDEADBEEF
) (
   input  logic                          CLOCK_PIN,
   input  logic                          RESET_PIN,
   input  logic [NUM_CORES-1:0]          core_req,
   input  logic [NUM_CORES-1:0]          core_write,
   input  logic [NUM_CORES*ADDR_W-1:0]   core_addr,
   input  logic [NUM_CORES*DATA_W-1:0]   core_wdata,
   output logic [NUM_CORES-1:0]          core_ack,
   output logic [NUM_CORES-1:0]          core_err,
   output logic [DATA_W-1:0]             core_rdata,
   output logic                          mem_req,
   output logic                          mem_write,
   output logic [ADDR_W-1:0]             mem_addr,
   output logic [DATA_W-1:0]             mem_wdata,
   input  logic [DATA_W-1:0]             mem_rdata,
   input  logic                          mem_ack
);

   localparam int                IDX_W    = $clog2(NUM_CORES);
   localparam int                TMR_W    = $clog2(TIMEOUT);
   localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_CORES - 1);
   localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(TIMEOUT - 1);
   localparam logic [DATA_W-1:0] ERR_WORD = DATA_W'(ERR_DATA);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_BUSY,
      ST_RESP
   } state_t;

   state_t                 r_state;
   logic [IDX_W-1:0]       r_last_grant;
   logic [IDX_W-1:0]       r_winner;
   logic [TMR_W-1:0]       r_timer;
   logic                   r_err;
   logic [NUM_CORES-1:0]   r_core_ack;
   logic [NUM_CORES-1:0]   r_core_err;
   logic [DATA_W-1:0]      r_core_rdata;
   logic                   r_mem_req;
   logic                   r_mem_write;
   logic [ADDR_W-1:0]      r_mem_addr;
   logic [DATA_W-1:0]      r_mem_wdata;

   logic [ADDR_W-1:0]      w_addr  [NUM_CORES];
   logic [DATA_W-1:0]      w_wdata [NUM_CORES];
   logic                   w_found;
   logic [IDX_W-1:0]       w_grant;
   logic [NUM_CORES-1:0]   w_winner_oh;
   int                     w_scan;

   genvar g;
   generate
      for (g = 0; g < NUM_CORES; g++) begin : g_unpack
         assign w_addr[g]  = core_addr[g*ADDR_W +: ADDR_W];
         assign w_wdata[g] = core_wdata[g*DATA_W +: DATA_W];
      end
   endgenerate

   // Scan from the core after the last winner, wrapping, and take the first requester.
   always_comb begin
      // NOTE: every variable gets a default before the loop so no latch is inferred.
      w_found = 1'b0;
      w_grant = '0;
      w_scan  = 0;
      for (int i = 1; i <= NUM_CORES; i++) begin
         w_scan = (int'(r_last_grant) + i) % NUM_CORES;
         if (!w_found && core_req[IDX_W'(w_scan)]) begin
            w_found = 1'b1;
            w_grant = IDX_W'(w_scan);
         end
      end
   end

   assign w_winner_oh = NUM_CORES'(1) << r_winner;

   always_ff @(posedge CLOCK_PIN or posedge RESET_PIN) begin
      if (RESET_PIN) begin
         r_state      <= ST_IDLE;
         r_last_grant <= LAST_IDX;
         r_winner     <= '0;
         r_timer      <= '0;
         r_err        <= 1'b0;
         r_core_ack   <= '0;
         r_core_err   <= '0;
         r_core_rdata <= '0;
         r_mem_req    <= 1'b0;
         r_mem_write  <= 1'b0;
         r_mem_addr   <= '0;
         r_mem_wdata  <= '0;
      end else begin
         // NOTE: state is updated with non-blocking assignments so every branch sees pre-edge values.
         r_core_ack <= '0;
         r_core_err <= '0;
         case (r_state)
            ST_IDLE: begin
               // While the ack pulse is visible the requester still shows its old request: skip one cycle.
               if (w_found && (r_core_ack == '0)) begin
                  r_winner    <= w_grant;
                  r_mem_write <= core_write[w_grant];
                  r_mem_addr  <= w_addr[w_grant];
                  r_mem_wdata <= w_wdata[w_grant];
                  r_mem_req   <= 1'b1;
                  r_timer     <= '0;
                  r_state     <= ST_BUSY;
               end
            end
            ST_BUSY: begin
               if (mem_ack) begin
                  r_core_rdata <= r_mem_write ? '0 : mem_rdata;
                  r_mem_req    <= 1'b0;
                  r_state      <= ST_RESP;
               end else if (r_timer == TMR_LAST) begin
                  r_core_rdata <= ERR_WORD;
                  r_err        <= 1'b1;
                  r_mem_req    <= 1'b0;
                  r_state      <= ST_RESP;
               end else begin
                  r_timer <= r_timer + 1'b1;
               end
            end
            ST_RESP: begin
               r_core_ack   <= w_winner_oh;
               r_core_err   <= r_err ? w_winner_oh : '0;
               r_last_grant <= r_winner;
               r_err        <= 1'b0;
               r_state      <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign core_ack   = r_core_ack;
   assign core_err   = r_core_err;
   assign core_rdata = r_core_rdata;
   assign mem_req    = r_mem_req;
   assign mem_write  = r_mem_write;
   assign mem_addr   = r_mem_addr;
   assign mem_wdata  = r_mem_wdata;

endmodule

// File: tb/tb_ollar_bus_arbiter.sv
// Scoreboard bench for ollar_bus_arbiter: core drivers, a programmable-wait slave,
// and monitors that compare every ack and every slave request against queued expectations.
module tb_ollar_bus_arbiter;

   localparam int NC = 4;

   logic              CLOCK_PIN = 1'b0;
   logic              RESET_PIN;
   logic [NC-1:0]     core_req;
   logic [NC-1:0]     core_write;
   logic [NC*32-1:0]  core_addr;
   logic [NC*32-1:0]  core_wdata;
   logic [NC-1:0]     core_ack;
   logic [NC-1:0]     core_err;
   logic [31:0]       core_rdata;
   logic              mem_req;
   logic              mem_write;
   logic [31:0]       mem_addr;
   logic [31:0]       mem_wdata;
   logic [31:0]       mem_rdata;
   logic              mem_ack;

   ollar_bus_arbiter #(
      .NUM_CORES(NC), .ADDR_W(32), .DATA_W(32), .TIMEOUT(16), .ERR_DATA(32'hDEADBEEF)
   ) dut (
      .CLOCK_PIN (CLOCK_PIN),
      .RESET_PIN (RESET_PIN),
      .core_req  (core_req),
      .core_write(core_write),
      .core_addr (core_addr),
      .core_wdata(core_wdata),
      .core_ack  (core_ack),
      .core_err  (core_err),
      .core_rdata(core_rdata),
      .mem_req   (mem_req),
      .mem_write (mem_write),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_ack   (mem_ack)
   );

   always #5 CLOCK_PIN = ~CLOCK_PIN;

   typedef struct {
      int          core;
      logic        err;
      logic [31:0] rdata;
      int          lat;
   } ack_exp_t;

   typedef struct {
      logic        write;
      logic [31:0] addr;
      logic [31:0] wdata;
      int          len;
   } mem_exp_t;

   ack_exp_t ack_q[$];
   mem_exp_t mem_q[$];
   ack_exp_t ack_cur;
   mem_exp_t mem_cur;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int pend[NC];
   bit drop_pend[NC];
   int raise_cyc[NC];
   int slave_wait = 0;
   int busy_cnt   = 0;
   int mem_len    = 0;
   logic mem_prev = 1'b0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] exp_rdata(input logic [31:0] addr);
      return (addr == 32'h100) ? 32'hCAFEF00D : {addr[15:0], 16'h5A5A};
   endfunction

   task automatic issue(input int c, input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
      core_write[c]         = wr;
      core_addr[c*32 +: 32]  = addr;
      core_wdata[c*32 +: 32] = wdata;
      pend[c]                = pend[c] + 1;
   endtask

   task automatic expect_txn(input int c, input logic wr, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic err, input int lat, input int len);
      logic [31:0] rd;
      rd = wr ? 32'h0 : (err ? 32'hDEADBEEF : exp_rdata(addr));
      ack_q.push_back('{c, err, rd, lat});
      mem_q.push_back('{wr, addr, wdata, len});
   endtask

   task automatic wait_done(input int budget);
      int n = 0;
      while ((ack_q.size() != 0 || mem_q.size() != 0 || core_req != 0 ||
              (pend[0] + pend[1] + pend[2] + pend[3]) != 0) && n < budget) begin
         @(negedge CLOCK_PIN);
         n++;
      end
      check("wait_idle", 64'(n < budget), 64'd1);
      repeat (3) @(negedge CLOCK_PIN);
   endtask

   initial forever begin
      @(posedge CLOCK_PIN);
      cyc++;
   end

   // Core drivers: drop the request on the edge after the ack was seen, raise the next pending one later.
   initial forever begin
      @(posedge CLOCK_PIN);
      #1;
      for (int c = 0; c < NC; c++) begin
         if (drop_pend[c]) begin
            core_req[c]  = 1'b0;
            drop_pend[c] = 1'b0;
         end else if (!core_req[c] && pend[c] > 0) begin
            core_req[c]  = 1'b1;
            pend[c]      = pend[c] - 1;
            raise_cyc[c] = cyc;
         end
      end
   end

   // Slave: acks after slave_wait cycles of mem_req; a negative wait never acks.
   initial forever begin
      @(posedge CLOCK_PIN);
      #1;
      mem_ack = 1'b0;
      if (mem_req) begin
         if (busy_cnt == slave_wait) begin
            mem_ack   = 1'b1;
            mem_rdata = exp_rdata(mem_addr);
         end
         busy_cnt++;
      end else begin
         busy_cnt = 0;
      end
   end

   initial forever begin
      @(negedge CLOCK_PIN);
      if (core_ack != '0) begin
         if (ack_q.size() == 0) begin
            check("ack_unexpected", 64'(core_ack), 64'd0);
         end else begin
            ack_cur = ack_q.pop_front();
            check("ack_vec",   64'(core_ack),   64'(4'b0001 << ack_cur.core));
            check("ack_err",   64'(core_err),   ack_cur.err ? 64'(4'b0001 << ack_cur.core) : 64'd0);
            check("ack_rdata", 64'(core_rdata), 64'(ack_cur.rdata));
            if (ack_cur.lat >= 0)
               check("ack_latency", 64'(cyc - raise_cyc[ack_cur.core]), 64'(ack_cur.lat));
         end
         for (int c = 0; c < NC; c++)
            if (core_ack[c]) drop_pend[c] = 1'b1;
      end else if (core_err != '0) begin
         check("err_without_ack", 64'(core_err), 64'd0);
      end
   end

   initial forever begin
      @(negedge CLOCK_PIN);
      if (mem_req && !mem_prev) begin
         if (mem_q.size() == 0) begin
            check("mem_unexpected", 64'(mem_addr), 64'hFFFF_FFFF_FFFF_FFFF);
            mem_cur = '{1'b0, 32'h0, 32'h0, -1};
         end else begin
            mem_cur = mem_q.pop_front();
            check("mem_addr",  64'(mem_addr),  64'(mem_cur.addr));
            check("mem_write", 64'(mem_write), 64'(mem_cur.write));
            check("mem_wdata", 64'(mem_wdata), 64'(mem_cur.wdata));
         end
         mem_len = 1;
      end else if (mem_req) begin
         mem_len++;
         check("mem_hold_addr",  64'(mem_addr),  64'(mem_cur.addr));
         check("mem_hold_wdata", 64'(mem_wdata), 64'(mem_cur.wdata));
      end else if (mem_prev && mem_cur.len >= 0) begin
         check("mem_req_len", 64'(mem_len), 64'(mem_cur.len));
      end
      mem_prev = mem_req;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      RESET_PIN  = 1'b1;
      core_req   = '0;
      core_write = '0;
      core_addr  = '0;
      core_wdata = '0;
      mem_rdata  = '0;
      mem_ack    = 1'b0;
      for (int c = 0; c < NC; c++) begin
         pend[c] = 0; drop_pend[c] = 1'b0; raise_cyc[c] = 0;
      end
      #3;
      check("rst_core_ack",   64'(core_ack),   64'd0);
      check("rst_core_err",   64'(core_err),   64'd0);
      check("rst_core_rdata", 64'(core_rdata), 64'd0);
      check("rst_mem_req",    64'(mem_req),    64'd0);
      check("rst_mem_write",  64'(mem_write),  64'd0);
      check("rst_mem_addr",   64'(mem_addr),   64'd0);
      check("rst_mem_wdata",  64'(mem_wdata),  64'd0);
      repeat (2) @(negedge CLOCK_PIN);
      RESET_PIN = 1'b0;
      @(negedge CLOCK_PIN);

      // Round-robin from reset: order 0,1,2,3,0,1.
      slave_wait = 0;
      for (int c = 0; c < NC; c++) issue(c, 1'b0, 32'h1000 + 32'(c) * 32'h10, 32'h0);
      issue(0, 1'b0, 32'h1000, 32'h0);
      issue(1, 1'b0, 32'h1010, 32'h0);
      expect_txn(0, 1'b0, 32'h1000, 32'h0, 1'b0, -1, 1);
      expect_txn(1, 1'b0, 32'h1010, 32'h0, 1'b0, -1, 1);
      expect_txn(2, 1'b0, 32'h1020, 32'h0, 1'b0, -1, 1);
      expect_txn(3, 1'b0, 32'h1030, 32'h0, 1'b0, -1, 1);
      expect_txn(0, 1'b0, 32'h1000, 32'h0, 1'b0, -1, 1);
      expect_txn(1, 1'b0, 32'h1010, 32'h0, 1'b0, -1, 1);
      wait_done(200);

      // Single read from core 2 with a zero-wait slave: 3 cycles request to ack.
      slave_wait = 0;
      issue(2, 1'b0, 32'h100, 32'h0);
      expect_txn(2, 1'b0, 32'h100, 32'h0, 1'b0, 3, 1);
      wait_done(50);

      // Write from core 1 against a 3-wait slave.
      slave_wait = 3;
      issue(1, 1'b1, 32'h20, 32'h12345678);
      expect_txn(1, 1'b1, 32'h20, 32'h12345678, 1'b0, -1, 4);
      wait_done(50);

      // Timeout: the slave never answers.
      slave_wait = -1;
      issue(0, 1'b0, 32'h40, 32'h0);
      expect_txn(0, 1'b0, 32'h40, 32'h0, 1'b1, -1, 16);
      wait_done(80);

      // Core 0 proceeds normally after the timeout.
      slave_wait = 0;
      issue(0, 1'b0, 32'h44, 32'h0);
      expect_txn(0, 1'b0, 32'h44, 32'h0, 1'b0, 3, 1);
      wait_done(50);

      // Ack on the last cycle before the timeout wins.
      slave_wait = 15;
      issue(0, 1'b0, 32'h80, 32'h0);
      expect_txn(0, 1'b0, 32'h80, 32'h0, 1'b0, -1, 16);
      wait_done(80);

      // Reset in the middle of a core 3 transaction.
      slave_wait = -1;
      issue(3, 1'b0, 32'h300, 32'h0);
      mem_q.push_back('{1'b0, 32'h300, 32'h0, -1});
      for (int n = 0; n < 20 && !mem_req; n++) @(negedge CLOCK_PIN);
      check("mid_busy_req", 64'(mem_req), 64'd1);
      repeat (3) @(negedge CLOCK_PIN);
      #2;
      RESET_PIN = 1'b1;
      for (int c = 0; c < NC; c++) begin
         pend[c] = 0; drop_pend[c] = 1'b0;
      end
      core_req = '0;
      #1;
      check("arst_mem_req",    64'(mem_req),    64'd0);
      check("arst_mem_addr",   64'(mem_addr),   64'd0);
      check("arst_core_ack",   64'(core_ack),   64'd0);
      check("arst_core_rdata", 64'(core_rdata), 64'd0);
      @(posedge CLOCK_PIN);
      @(negedge CLOCK_PIN);
      RESET_PIN = 1'b0;
      @(negedge CLOCK_PIN);

      // After reset core 0 has priority over core 3.
      slave_wait = 0;
      issue(3, 1'b0, 32'h300, 32'h0);
      issue(0, 1'b0, 32'h10, 32'h0);
      expect_txn(0, 1'b0, 32'h10,  32'h0, 1'b0, -1, 1);
      expect_txn(3, 1'b0, 32'h300, 32'h0, 1'b0, -1, 1);
      wait_done(80);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
